// File: rtl/pc_sequencer.sv
// Instruction sequencer: walks fetch/execute/memory/update phases, drives the
// program-counter controls and flags memory timeouts.
module pc_sequencer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        mem_op,
    input  logic        dmem_ack,
    input  logic        jump,
    input  logic        halt,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        pc_disable,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } st_e;

    st_e                cur_st;
    st_e                nxt_st;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_c;

    // Last permitted wait cycle; an ack arriving in this cycle still wins.
    assign timeout_c = (wait_cnt == CNT_W'(MAX_WAIT));

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (start) nxt_st = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)       nxt_st = ST_EXEC;
                else if (timeout_c) nxt_st = ST_FAULT;
            end
            ST_EXEC: begin
                if (halt)        nxt_st = ST_HALTED;
                else if (mem_op) nxt_st = ST_MEM;
                else             nxt_st = ST_UPDATE;
            end
            ST_MEM: begin
                if (dmem_ack)       nxt_st = ST_UPDATE;
                else if (timeout_c) nxt_st = ST_FAULT;
            end
            ST_UPDATE: nxt_st = ST_FETCH;
            ST_HALTED: nxt_st = ST_HALTED;
            ST_FAULT:  nxt_st = ST_FAULT;
            default:   nxt_st = ST_IDLE;
        endcase
    end

    // Output decode; pc_inc is the only output that also looks at an input
    always_comb begin
        imem_req   = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_disable = 1'b1;
        fault      = 1'b0;
        case (cur_st)
            ST_FETCH: imem_req = 1'b1;
            ST_UPDATE: begin
                pc_load    = 1'b1;
                pc_disable = 1'b0;
                pc_inc     = ~jump;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = cur_st;

    // Instruction latch and wait counter; counter is zero whenever not waiting
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr       <= INSTR_W'(0);
            instr_valid <= 1'b0;
            wait_cnt    <= CNT_W'(0);
        end else begin
            instr_valid <= 1'b0;
            if ((cur_st == ST_FETCH) && imem_ack) begin
                instr       <= imem_instr;
                instr_valid <= 1'b1;
            end
            if (((cur_st == ST_FETCH) || (cur_st == ST_MEM)) && (nxt_st == cur_st)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= CNT_W'(0);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed per-cycle rows push expected
// outputs; a negedge monitor pops and compares.
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_UPD = 3'd4, S_HALT = 3'd5, S_FLT = 3'd6;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] instr;
        logic        iv;
        logic        req;
        logic        load;
        logic        inc;
        logic        dis;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_instr = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_op = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        jump = 1'b0;
    logic        halt = 1'b0;
    logic        pc_load, pc_inc, pc_disable, fault;
    logic [2:0]  state;

    exp_t        exp_q[$];
    logic [31:0] iq[$];
    exp_t        mon_e, mon_g;
    logic [31:0] mon_w;
    int          n_checks = 0;
    int          n_fail = 0;

    pc_sequencer #(.MAX_WAIT(15)) dut (
        .clk(clk), .clr(clr), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_instr(imem_instr),
        .instr(instr), .instr_valid(instr_valid),
        .mem_op(mem_op), .dmem_ack(dmem_ack), .jump(jump), .halt(halt),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_disable(pc_disable),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // One clock cycle: expected outputs for the current state, inputs applied in it
    task automatic row(input logic r_clr, input logic r_start, input logic r_ack,
                       input logic [31:0] r_iw, input logic r_mop, input logic r_dack,
                       input logic r_jmp, input logic r_hlt,
                       input logic [2:0] est, input logic [31:0] einstr, input logic eiv);
        exp_t e;
        @(posedge clk);
        #1;
        clr = r_clr; start = r_start; imem_ack = r_ack; imem_instr = r_iw;
        mem_op = r_mop; dmem_ack = r_dack; jump = r_jmp; halt = r_hlt;
        e.st    = est;
        e.instr = einstr;
        e.iv    = eiv;
        e.req   = (est == S_FETCH);
        e.load  = (est == S_UPD);
        e.inc   = (est == S_UPD) && !r_jmp;
        e.dis   = (est != S_UPD);
        e.flt   = (est == S_FLT);
        exp_q.push_back(e);
        if (r_clr && est == S_FETCH && r_ack) iq.push_back(r_iw);
    endtask

    // Monitor: per-cycle output check plus instruction check on each instr_valid pulse
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_g = {state, instr, instr_valid, imem_req, pc_load, pc_inc, pc_disable, fault};
            n_checks++;
            if (mon_g !== mon_e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got st=%0d instr=%h iv=%b req=%b ld=%b inc=%b dis=%b flt=%b expected st=%0d instr=%h iv=%b req=%b ld=%b inc=%b dis=%b flt=%b",
                         $time, mon_g.st, mon_g.instr, mon_g.iv, mon_g.req, mon_g.load, mon_g.inc, mon_g.dis, mon_g.flt,
                         mon_e.st, mon_e.instr, mon_e.iv, mon_e.req, mon_e.load, mon_e.inc, mon_e.dis, mon_e.flt);
            end
        end
        if (instr_valid === 1'b1) begin
            n_checks++;
            if (iq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr_valid t=%0t got instr=%h expected no pulse", $time, instr);
            end else begin
                mon_w = iq.pop_front();
                if (instr !== mon_w) begin
                    n_fail++;
                    $display("FAIL fetched_instr t=%0t got %h expected %h", $time, instr, mon_w);
                end
            end
        end
    end

    localparam logic [31:0] NOP = 32'h0000_0013, LW = 32'h00A0_2283, JAL = 32'h0000_006F,
                            HLTW = 32'h1111_1111, JUNK = 32'hDEAD_BEEF, SW = 32'h0000_2003;

    initial begin
        // clr sta ack iw    mop dak jmp hlt  state    instr iv
        row(0, 0, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        row(1, 1, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        // back-to-back non-memory instructions: 3 cycles each
        row(1, 0, 1, NOP,   0, 0, 0, 0, S_FETCH, 32'h0, 0);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_EXEC,  NOP, 1);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_UPD,   NOP, 0);
        for (int k = 0; k < 2; k++) begin
            row(1, 0, 1, NOP,   0, 0, 0, 0, S_FETCH, NOP, 0);
            row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_EXEC,  NOP, 1);
            row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_UPD,   NOP, 0);
        end
        // load: MEM held 5 cycles, stray imem acks ignored
        row(1, 0, 1, LW,    0, 0, 0, 0, S_FETCH, NOP, 0);
        row(1, 0, 0, 32'h0, 1, 0, 0, 0, S_EXEC,  LW, 1);
        for (int k = 0; k < 4; k++) row(1, 0, 1, JUNK, 0, 0, 0, 0, S_MEM, LW, 0);
        row(1, 0, 0, 32'h0, 0, 1, 0, 0, S_MEM,   LW, 0);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_UPD,   LW, 0);
        // jump: pc_load without pc_inc
        row(1, 0, 1, JAL,   0, 0, 0, 0, S_FETCH, LW, 0);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_EXEC,  JAL, 1);
        row(1, 0, 0, 32'h0, 0, 0, 1, 0, S_UPD,   JAL, 0);
        // fetch ack on the 16th (terminal) wait cycle still proceeds
        for (int k = 0; k < 15; k++) row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_FETCH, JAL, 0);
        row(1, 0, 1, HLTW,  0, 0, 0, 0, S_FETCH, JAL, 0);
        // halt beats mem_op; HALTED ignores start and acks
        row(1, 0, 0, 32'h0, 1, 0, 0, 1, S_EXEC,  HLTW, 1);
        for (int k = 0; k < 3; k++) row(1, 1, 1, JUNK, 1, 1, 0, 0, S_HALT, HLTW, 0);
        // reset, then a fetch that never acks -> sticky FAULT
        row(0, 0, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        row(1, 1, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        for (int k = 0; k < 16; k++) row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_FETCH, 32'h0, 0);
        for (int k = 0; k < 3; k++) row(1, 1, 1, JUNK, 0, 1, 0, 0, S_FLT, 32'h0, 0);
        // reset asserted mid-cycle from FAULT, then mid-MEM; late acks ignored
        row(0, 0, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        row(1, 1, 0, 32'h0, 0, 0, 0, 0, S_IDLE, 32'h0, 0);
        row(1, 0, 1, SW,    0, 0, 0, 0, S_FETCH, 32'h0, 0);
        row(1, 0, 0, 32'h0, 1, 0, 0, 0, S_EXEC,  SW, 1);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_MEM,   SW, 0);
        row(0, 0, 0, 32'h0, 0, 0, 0, 0, S_IDLE,  32'h0, 0);
        row(1, 0, 1, JUNK,  0, 1, 0, 0, S_IDLE,  32'h0, 0);
        row(1, 0, 0, 32'h0, 0, 1, 0, 0, S_IDLE,  32'h0, 0);
        row(1, 0, 0, 32'h0, 0, 0, 0, 0, S_IDLE,  32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || iq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d rows and %0d instrs pending expected 0 and 0", exp_q.size(), iq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
